vending_machine_param: RTL and testbench

VENDING_MACHINE_PARAM -- requirements
Module: vending_machine_param

---
 rtl/vending_machine_param.sv | 172 +++++++++++++++++
 tb/tb_vending_machine_param.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/vending_machine_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | vending_machine_param: coin-accepting vending controller with parameterised |
// | products and prices. Define VEND_STOCK_EN for per-product stock counters.  |
// | Revision: 1.0                                                             |
// +----------------------------------------------------------------------------+
module vending_machine_param #(
  parameter int NUM_PRODUCTS = 4,
  parameter int CREDIT_W = 6,
  parameter int MAX_CREDIT = 50,
  parameter logic [8*NUM_PRODUCTS-1:0] PRICES = {8'd20, 8'd15, 8'd10, 8'd5},
  parameter int STOCK_INIT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    coin_valid,
  input  logic [1:0]              coin,
  input  logic                    sel_valid,
  input  logic [2:0]              product_select,
  input  logic                    cancel,
  output logic                    out,
  output logic [2:0]              vend_id,
  output logic                    change_valid,
  output logic [CREDIT_W-1:0]     change,
  output logic [CREDIT_W-1:0]     credit,
  output logic                    coin_reject,
  output logic                    deny,
  output logic [NUM_PRODUCTS-1:0] sold_out
);

  // Comparison width wide enough for credit, an 8-bit price and a carry.
  localparam int c_aw = ((CREDIT_W > 8) ? CREDIT_W : 8) + 1;
  localparam logic [c_aw-1:0] c_max_credit = c_aw'(MAX_CREDIT);
  localparam logic [3:0] c_num_products = 4'(NUM_PRODUCTS);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_COLLECT  = 2'd1,
    S_DISPENSE = 2'd2,
    S_RETURN   = 2'd3
  } state_t;

  state_t          r_state;
  logic [7:0]      w_price;
  logic            w_avail;
  logic [3:0]      w_coin_val;
  logic [c_aw-1:0] w_credit_x;
  logic [c_aw-1:0] w_price_x;
  logic [c_aw-1:0] w_sum;
  logic            w_coin_fits;
  logic            w_sel_in_range;
  logic            w_accept;

  always_comb begin
    w_price = '0;
    w_avail = 1'b0;
    for (int i = 0; i < NUM_PRODUCTS; i++) begin
      if (product_select == 3'(i)) begin
        w_price = PRICES[8*i +: 8];
        w_avail = ~sold_out[i];
      end
    end
  end

  always_comb begin
    case (coin)
      2'd0:    w_coin_val = 4'd1;
      2'd1:    w_coin_val = 4'd2;
      2'd2:    w_coin_val = 4'd5;
      default: w_coin_val = 4'd10;
    endcase
  end

  assign w_credit_x     = {{(c_aw-CREDIT_W){1'b0}}, credit};
  assign w_price_x      = {{(c_aw-8){1'b0}}, w_price};
  assign w_sum          = w_credit_x + {{(c_aw-4){1'b0}}, w_coin_val};
  assign w_coin_fits    = (w_sum <= c_max_credit);
  assign w_sel_in_range = ({1'b0, product_select} < c_num_products);
  assign w_accept       = (r_state == S_COLLECT) && !cancel && sel_valid &&
                          w_sel_in_range && (w_credit_x >= w_price_x) && w_avail;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      credit       <= '0;
      out          <= 1'b0;
      vend_id      <= '0;
      change_valid <= 1'b0;
      change       <= '0;
      coin_reject  <= 1'b0;
      deny         <= 1'b0;
    end else begin
      out          <= 1'b0;
      vend_id      <= '0;
      change_valid <= 1'b0;
      change       <= '0;
      coin_reject  <= 1'b0;
      deny         <= 1'b0;
      case (r_state)
        S_IDLE, S_COLLECT: begin
          // Cancel only has meaning with credit held; in IDLE it is transparent.
          if (cancel && (r_state == S_COLLECT)) begin
            change_valid <= 1'b1;
            change       <= credit;
            credit       <= '0;
            coin_reject  <= coin_valid;
            r_state      <= S_RETURN;
          end else if (sel_valid) begin
            coin_reject <= coin_valid;
            if (w_accept) begin
              out     <= 1'b1;
              vend_id <= product_select;
              credit  <= CREDIT_W'(w_credit_x - w_price_x);
              r_state <= S_DISPENSE;
            end else begin
              deny <= 1'b1;
            end
          end else if (coin_valid) begin
            if (w_coin_fits) begin
              credit  <= CREDIT_W'(w_sum);
              r_state <= S_COLLECT;
            end else begin
              coin_reject <= 1'b1;
            end
          end
        end
        S_DISPENSE: begin
          coin_reject <= coin_valid;
          deny        <= sel_valid;
          if (credit != '0) begin
            change_valid <= 1'b1;
            change       <= credit;
            credit       <= '0;
            r_state      <= S_RETURN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RETURN: begin
          coin_reject <= coin_valid;
          deny        <= sel_valid;
          r_state     <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

`ifdef VEND_STOCK_EN
  localparam int c_stock_w = (STOCK_INIT < 2) ? 1 : $clog2(STOCK_INIT + 1);
  localparam logic [c_stock_w-1:0] c_stock_init = c_stock_w'(STOCK_INIT);
  localparam logic [c_stock_w-1:0] c_stock_one  = c_stock_w'(1);

  generate
    for (genvar gi = 0; gi < NUM_PRODUCTS; gi++) begin : g_stock
      logic [c_stock_w-1:0] r_stock;
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          r_stock <= c_stock_init;
        end else if (w_accept && (product_select == 3'(gi))) begin
          r_stock <= r_stock - c_stock_one;
        end
      end
      assign sold_out[gi] = (r_stock == '0);
    end
  endgenerate
`else
  assign sold_out = '0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_vending_machine_param.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_vending_machine_param: directed and random stimulus against a           |
// | transaction-level model of the vending rules. Revision: 1.0                |
// +----------------------------------------------------------------------------+
module tb_vending_machine_param;

  localparam int NP = 4;
  localparam int CW = 6;
  localparam int MAXC = 50;
  localparam int SINIT = 3;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          coin_valid = 1'b0;
  logic [1:0]    coin = '0;
  logic          sel_valid = 1'b0;
  logic [2:0]    product_select = '0;
  logic          cancel = 1'b0;
  logic          out;
  logic [2:0]    vend_id;
  logic          change_valid;
  logic [CW-1:0] change;
  logic [CW-1:0] credit;
  logic          coin_reject;
  logic          deny;
  logic [NP-1:0] sold_out;

  vending_machine_param dut (
    .clk(clk), .rst(rst), .coin_valid(coin_valid), .coin(coin),
    .sel_valid(sel_valid), .product_select(product_select), .cancel(cancel),
    .out(out), .vend_id(vend_id), .change_valid(change_valid), .change(change),
    .credit(credit), .coin_reject(coin_reject), .deny(deny), .sold_out(sold_out)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: credit balance, pending vend/refund cycles, stock on hand.
  int price_tab [0:3] = '{5, 10, 15, 20};
  int coin_tab  [0:3] = '{1, 2, 5, 10};
  int m_credit;
  bit m_vending;
  bit m_refunding;
  int m_stock [0:3];
  int e_out, e_id, e_cv, e_chg, e_rej, e_deny;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_credit = 0;
    m_vending = 0;
    m_refunding = 0;
    for (int i = 0; i < NP; i++) m_stock[i] = SINIT;
    e_out = 0; e_id = 0; e_cv = 0; e_chg = 0; e_rej = 0; e_deny = 0;
  endtask

  task automatic check_all(input string tag);
    logic [NP-1:0] so;
    so = '0;
`ifdef VEND_STOCK_EN
    for (int i = 0; i < NP; i++) so[i] = (m_stock[i] == 0);
`endif
    chk({tag, ".out"}, 32'(out), e_out);
    chk({tag, ".vend_id"}, 32'(vend_id), e_id);
    chk({tag, ".change_valid"}, 32'(change_valid), e_cv);
    chk({tag, ".change"}, 32'(change), e_chg);
    chk({tag, ".credit"}, 32'(credit), m_credit);
    chk({tag, ".coin_reject"}, 32'(coin_reject), e_rej);
    chk({tag, ".deny"}, 32'(deny), e_deny);
    chk({tag, ".sold_out"}, 32'(sold_out), 32'(so));
  endtask

  task automatic step(input string tag, input bit cv, input int c, input bit sv,
                      input int ps, input bit can);
    bit in_stock;
    coin_valid = cv; coin = 2'(c); sel_valid = sv; product_select = 3'(ps); cancel = can;
    e_out = 0; e_id = 0; e_cv = 0; e_chg = 0; e_rej = 0; e_deny = 0;
    if (m_vending) begin
      e_rej = cv; e_deny = sv; m_vending = 0;
      if (m_credit > 0) begin
        e_cv = 1; e_chg = m_credit; m_credit = 0; m_refunding = 1;
      end
    end else if (m_refunding) begin
      e_rej = cv; e_deny = sv; m_refunding = 0;
    end else if (can && m_credit > 0) begin
      e_cv = 1; e_chg = m_credit; m_credit = 0; m_refunding = 1; e_rej = cv;
    end else if (sv) begin
      e_rej = cv;
      e_deny = 1;
      if (m_credit > 0 && ps < NP) begin
`ifdef VEND_STOCK_EN
        in_stock = (m_stock[ps] > 0);
`else
        in_stock = 1;
`endif
        if (in_stock && m_credit >= price_tab[ps]) begin
          e_deny = 0; e_out = 1; e_id = ps;
          m_credit -= price_tab[ps];
          m_vending = 1;
          m_stock[ps]--;
        end
      end
    end else if (cv) begin
      if (m_credit + coin_tab[c] > MAXC) e_rej = 1;
      else m_credit += coin_tab[c];
    end
    @(posedge clk);
    #1;
    check_all(tag);
    coin_valid = 0; sel_valid = 0; cancel = 0;
  endtask

  task automatic idle(input string tag);
    step(tag, 0, 0, 0, 0, 0);
  endtask

  // Reset raised between clock edges; credit must clear with no edge involved.
  task automatic async_reset(input string tag);
    #2 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #2 rst = 1'b0;
  endtask

  initial begin
    model_reset();
    #12;
    check_all("reset");
    rst = 1'b0;

    // Coins 5,5 then product 1.
    step("r38_c1", 1, 2, 0, 0, 0);
    step("r38_c2", 1, 2, 0, 0, 0);
    step("r38_sel", 0, 0, 1, 1, 0);
    idle("r38_d1");
    idle("r38_d2");

    // Coins 10,10 then product 2, change 5.
    step("r39_c1", 1, 3, 0, 0, 0);
    step("r39_c2", 1, 3, 0, 0, 0);
    step("r39_sel", 0, 0, 1, 2, 0);
    idle("r39_ret");
    idle("r39_done");

    // Fill to the ceiling, overflow coin, cancel.
    for (int i = 0; i < 5; i++) step("r40_fill", 1, 3, 0, 0, 0);
    step("r40_over", 1, 0, 0, 0, 0);
    step("r40_cancel", 0, 0, 0, 0, 1);
    idle("r40_done");

    // Underfunded selection, then selection with cancel.
    step("r41_coin", 1, 1, 0, 0, 0);
    step("r41_deny", 0, 0, 1, 0, 0);
    step("r41_both", 0, 0, 1, 0, 1);
    idle("r41_done");

    // Edge cases: idle select, out-of-range product, coin with selection.
    step("idle_sel", 0, 0, 1, 0, 0);
    step("idle_cancel", 0, 0, 0, 0, 1);
    step("bad_c", 1, 3, 0, 0, 0);
    step("bad_sel", 1, 2, 1, 6, 0);
    step("bad_cancel", 0, 0, 0, 0, 1);
    idle("bad_done");

    // Deplete product 0, then a fourth attempt.
    for (int k = 0; k < 3; k++) begin
      step("r42_coin", 1, 2, 0, 0, 0);
      step("r42_sel", 0, 0, 1, 0, 0);
      idle("r42_idle");
    end
    step("r42_coin4", 1, 2, 0, 0, 0);
    step("r42_sel4", 0, 0, 1, 0, 0);
    step("r42_cancel", 0, 0, 0, 0, 1);
    idle("r42_idle4");
    idle("r42_idle5");

    // Reset during COLLECT with credit 15.
    step("r43_c1", 1, 3, 0, 0, 0);
    step("r43_c2", 1, 2, 0, 0, 0);
    async_reset("r43_rst");
    idle("r43_after1");
    idle("r43_after2");

    for (int n = 0; n < 800; n++) begin
      if ($urandom_range(0, 99) == 0) begin
        async_reset("rnd_rst");
      end else begin
        step("rnd",
             ($urandom_range(0, 99) < 55),
             int'($urandom_range(0, 3)),
             ($urandom_range(0, 99) < 20),
             int'($urandom_range(0, 5)),
             ($urandom_range(0, 99) < 4));
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
